// File: rtl/vector_floating_point_minmax_sequencer_pkg.sv
// Shared types and constants for the FP min/max sequencer slice: decoded op,
// group size and sequencer state.
package vector_floating_point_minmax_sequencer_pkg;

    localparam int RISCV_VLEN = 128;
    localparam int REGISTER_ADDRESS_WIDTH = 5;

    typedef logic [1:0] lmul_log2_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } sequencer_state_t;

    typedef enum logic {
        OP_VFMIN = 1'b0,
        OP_VFMAX = 1'b1
    } minmax_op_t;

    typedef enum logic {
        SEW_32 = 1'b0,
        SEW_64 = 1'b1
    } sew_t;

    typedef struct packed {
        minmax_op_t op;
        sew_t       sew;
    } execution_vector_t;

endpackage

// File: rtl/vector_floating_point_minmax_sequencer_if.sv
// Issue-side request handshake plus register-file read/write ports of the
// FP min/max sequencer; the sequencer is the slave, the environment the master.
interface vector_floating_point_minmax_sequencer_if
    import vector_floating_point_minmax_sequencer_pkg::*;
#(
    parameter int VLEN = RISCV_VLEN,
    parameter int REGISTER_ADDRESS_WIDTH = vector_floating_point_minmax_sequencer_pkg::REGISTER_ADDRESS_WIDTH
) ();

    logic                              request_valid;
    logic                              request_ready;
    execution_vector_t                 execution_vector;
    lmul_log2_t                        lmul_log2;
    logic [REGISTER_ADDRESS_WIDTH-1:0] vs2_address;
    logic [REGISTER_ADDRESS_WIDTH-1:0] vs1_address;
    logic [REGISTER_ADDRESS_WIDTH-1:0] vd_address;

    logic                              rf_read_enable;
    logic [REGISTER_ADDRESS_WIDTH-1:0] rf_read_address_a;
    logic [REGISTER_ADDRESS_WIDTH-1:0] rf_read_address_b;
    logic [VLEN-1:0]                   rf_read_data_a;
    logic [VLEN-1:0]                   rf_read_data_b;
    logic                              rf_write_enable;
    logic [REGISTER_ADDRESS_WIDTH-1:0] rf_write_address;
    logic [VLEN-1:0]                   rf_write_data;

    logic                              busy;
    logic                              done;

    modport slave (
        input  request_valid, execution_vector, lmul_log2,
               vs2_address, vs1_address, vd_address,
               rf_read_data_a, rf_read_data_b,
        output request_ready, rf_read_enable, rf_read_address_a, rf_read_address_b,
               rf_write_enable, rf_write_address, rf_write_data, busy, done
    );

    modport master (
        output request_valid, execution_vector, lmul_log2,
               vs2_address, vs1_address, vd_address,
               rf_read_data_a, rf_read_data_b,
        input  request_ready, rf_read_enable, rf_read_address_a, rf_read_address_b,
               rf_write_enable, rf_write_address, rf_write_data, busy, done
    );

endinterface

// File: rtl/vector_floating_point_minmax_sequencer_unit.sv
// Combinational lane-wise vfmin/vfmax over one vector register, SEW 32 or 64,
// with RISC-V NaN handling (one NaN yields the other operand) and -0 < +0.
module vector_floating_point_minmax_unit
    import vector_floating_point_minmax_sequencer_pkg::*;
#(
    parameter int VLEN = RISCV_VLEN
) (
    input  execution_vector_t execution_vector,
    input  logic [VLEN-1:0]   vs2,
    input  logic [VLEN-1:0]   vs1,
    output logic [VLEN-1:0]   vd
);

    function automatic logic [31:0] minmax32(input logic [31:0] a, input logic [31:0] b,
                                             input logic is_max);
        logic a_nan;
        logic b_nan;
        logic a_lt_b;
        logic [31:0] r;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (a[31] != b[31])  a_lt_b = a[31];
        else if (a[31])      a_lt_b = a[30:0] > b[30:0];
        else                 a_lt_b = a[30:0] < b[30:0];
        if (a_nan && b_nan)           r = 32'h7FC0_0000;
        else if (a_nan)               r = b;
        else if (b_nan)               r = a;
        else if (a_lt_b ^ is_max)     r = a;
        else                          r = b;
        return r;
    endfunction

    function automatic logic [63:0] minmax64(input logic [63:0] a, input logic [63:0] b,
                                             input logic is_max);
        logic a_nan;
        logic b_nan;
        logic a_lt_b;
        logic [63:0] r;
        a_nan = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
        b_nan = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
        if (a[63] != b[63])  a_lt_b = a[63];
        else if (a[63])      a_lt_b = a[62:0] > b[62:0];
        else                 a_lt_b = a[62:0] < b[62:0];
        if (a_nan && b_nan)           r = 64'h7FF8_0000_0000_0000;
        else if (a_nan)               r = b;
        else if (b_nan)               r = a;
        else if (a_lt_b ^ is_max)     r = a;
        else                          r = b;
        return r;
    endfunction

    logic            is_max;
    logic [VLEN-1:0] result32;
    logic [VLEN-1:0] result64;

    assign is_max = (execution_vector.op == OP_VFMAX);

    always_comb begin
        result32 = '0;
        result64 = '0;
        for (int i = 0; i < VLEN / 32; i++) begin
            result32[i*32 +: 32] = minmax32(vs2[i*32 +: 32], vs1[i*32 +: 32], is_max);
        end
        for (int j = 0; j < VLEN / 64; j++) begin
            result64[j*64 +: 64] = minmax64(vs2[j*64 +: 64], vs1[j*64 +: 64], is_max);
        end
    end

    assign vd = (execution_vector.sew == SEW_64) ? result64 : result32;

endmodule

// File: rtl/vector_floating_point_minmax_sequencer.sv
// Sequences one vfmin/vfmax across an LMUL register group: streams reads,
// writes each min/max result one cycle behind, pulses done with the last write.
module vector_floating_point_minmax_sequencer
    import vector_floating_point_minmax_sequencer_pkg::*;
#(
    parameter int VLEN = RISCV_VLEN,
    parameter int REGISTER_ADDRESS_WIDTH = vector_floating_point_minmax_sequencer_pkg::REGISTER_ADDRESS_WIDTH
) (
    input logic clock,
    input logic n_reset,
    vector_floating_point_minmax_sequencer_if.slave bus
);

    localparam int AW = REGISTER_ADDRESS_WIDTH;

    sequencer_state_t  state_q;
    execution_vector_t execution_vector_q;
    logic [AW-1:0]     vs2_base_q;
    logic [AW-1:0]     vs1_base_q;
    logic [AW-1:0]     vd_base_q;
    logic [3:0]        group_size_q;
    logic [3:0]        k_q;

    logic              request_ready_q;
    logic              rf_read_enable_q;
    logic [AW-1:0]     rf_read_address_a_q;
    logic [AW-1:0]     rf_read_address_b_q;
    logic              rf_write_enable_q;
    logic [AW-1:0]     rf_write_address_q;
    logic              busy_q;
    logic              done_q;
    logic [VLEN-1:0]   minmax_result;

    // k_q is the index of the read currently on the bus; the write pointer is
    // its registered copy, so writes trail reads by exactly one cycle.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q             <= IDLE;
            execution_vector_q  <= '0;
            vs2_base_q          <= '0;
            vs1_base_q          <= '0;
            vd_base_q           <= '0;
            group_size_q        <= '0;
            k_q                 <= '0;
            request_ready_q     <= 1'b1;
            rf_read_enable_q    <= 1'b0;
            rf_read_address_a_q <= '0;
            rf_read_address_b_q <= '0;
            rf_write_enable_q   <= 1'b0;
            rf_write_address_q  <= '0;
            busy_q              <= 1'b0;
            done_q              <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.request_valid && request_ready_q) begin
                        execution_vector_q  <= bus.execution_vector;
                        vs2_base_q          <= bus.vs2_address;
                        vs1_base_q          <= bus.vs1_address;
                        vd_base_q           <= bus.vd_address;
                        group_size_q        <= 4'd1 << bus.lmul_log2;
                        k_q                 <= '0;
                        rf_read_enable_q    <= 1'b1;
                        rf_read_address_a_q <= bus.vs2_address;
                        rf_read_address_b_q <= bus.vs1_address;
                        request_ready_q     <= 1'b0;
                        busy_q              <= 1'b1;
                        state_q             <= STREAM;
                    end
                end
                STREAM: begin
                    rf_write_enable_q  <= 1'b1;
                    rf_write_address_q <= vd_base_q + AW'(k_q);
                    if (k_q == group_size_q - 4'd1) begin
                        rf_read_enable_q <= 1'b0;
                        done_q           <= 1'b1;
                        state_q          <= DRAIN;
                    end else begin
                        k_q                 <= k_q + 4'd1;
                        rf_read_address_a_q <= vs2_base_q + AW'(k_q + 4'd1);
                        rf_read_address_b_q <= vs1_base_q + AW'(k_q + 4'd1);
                    end
                end
                DRAIN: begin
                    rf_write_enable_q <= 1'b0;
                    done_q            <= 1'b0;
                    busy_q            <= 1'b0;
                    request_ready_q   <= 1'b1;
                    state_q           <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    vector_floating_point_minmax_unit #(
        .VLEN (VLEN)
    ) u_minmax (
        .execution_vector (execution_vector_q),
        .vs2              (bus.rf_read_data_a),
        .vs1              (bus.rf_read_data_b),
        .vd               (minmax_result)
    );

    assign bus.request_ready     = request_ready_q;
    assign bus.rf_read_enable    = rf_read_enable_q;
    assign bus.rf_read_address_a = rf_read_address_a_q;
    assign bus.rf_read_address_b = rf_read_address_b_q;
    assign bus.rf_write_enable   = rf_write_enable_q;
    assign bus.rf_write_address  = rf_write_address_q;
    assign bus.rf_write_data     = rf_write_enable_q ? minmax_result : '0;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;

endmodule

// File: tb/tb_vector_floating_point_minmax_sequencer.sv
// Directed bench for the FP min/max sequencer with a behavioural register file
// that returns read data one cycle after the strobe.
module tb_vector_floating_point_minmax_sequencer;
    import vector_floating_point_minmax_sequencer_pkg::*;

    localparam int VLEN = 128;

    logic clock;
    logic n_reset;

    vector_floating_point_minmax_sequencer_if #(.VLEN(VLEN), .REGISTER_ADDRESS_WIDTH(5)) bus ();

    vector_floating_point_minmax_sequencer #(
        .VLEN                   (VLEN),
        .REGISTER_ADDRESS_WIDTH (5)
    ) dut (
        .clock   (clock),
        .n_reset (n_reset),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [VLEN-1:0] regfile [32];
    logic            preload_enable;
    logic [4:0]      preload_address;
    logic [VLEN-1:0] preload_data;
    int              write_count = 0;
    int              done_count = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file: reads are registered, so a same-cycle write is not forwarded.
    always @(posedge clock) begin
        if (bus.rf_read_enable) begin
            bus.rf_read_data_a <= regfile[bus.rf_read_address_a];
            bus.rf_read_data_b <= regfile[bus.rf_read_address_b];
        end
        if (preload_enable) regfile[preload_address] <= preload_data;
        else if (bus.rf_write_enable) regfile[bus.rf_write_address] <= bus.rf_write_data;
        if (bus.rf_write_enable) write_count <= write_count + 1;
        if (bus.done) done_count <= done_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [VLEN-1:0] observed,
                               input logic [VLEN-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkAddress(input string tag, input logic [4:0] observed,
                                input logic [4:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic preloadRegister(input logic [4:0] address, input logic [VLEN-1:0] data);
        @(negedge clock);
        preload_enable  = 1'b1;
        preload_address = address;
        preload_data    = data;
        @(negedge clock);
        preload_enable  = 1'b0;
    endtask

    // Drives the request in cycle 0 and returns just after the accepting edge.
    task automatic applyStimulus(input minmax_op_t op, input sew_t sew, input lmul_log2_t lmul,
                                 input logic [4:0] vs2, input logic [4:0] vs1,
                                 input logic [4:0] vd);
        @(negedge clock);
        bus.execution_vector = '{op: op, sew: sew};
        bus.lmul_log2        = lmul;
        bus.vs2_address      = vs2;
        bus.vs1_address      = vs1;
        bus.vd_address       = vd;
        bus.request_valid    = 1'b1;
        checkFlag("ready_cycle0", bus.request_ready, 1'b1);
        @(posedge clock);
        #1;
        bus.request_valid = 1'b0;
    endtask

    logic [4:0]      t2_rd_a [4];
    logic [4:0]      t2_rd_b [4];
    logic [4:0]      t2_wr   [4];
    logic [VLEN-1:0] t2_data [4];
    logic [4:0]      t3_rd_a [4];
    logic [4:0]      t3_wr   [4];
    int              snapshot_writes;
    int              snapshot_dones;
    int              handshakes;

    initial begin
        n_reset              = 1'b0;
        preload_enable       = 1'b0;
        preload_address      = '0;
        preload_data         = '0;
        bus.request_valid    = 1'b0;
        bus.execution_vector = '{op: OP_VFMIN, sew: SEW_32};
        bus.lmul_log2        = '0;
        bus.vs2_address      = '0;
        bus.vs1_address      = '0;
        bus.vd_address       = '0;

        t2_rd_a = '{5'd0, 5'd1, 5'd2, 5'd3};
        t2_rd_b = '{5'd4, 5'd5, 5'd6, 5'd7};
        t2_wr   = '{5'd8, 5'd9, 5'd10, 5'd11};
        t2_data = '{ {32'h4000_0000, 32'hBF80_0000, 32'h4040_0000, 32'h0000_0000},
                     {4{32'h4000_0000}},
                     {4{32'hC040_0000}},
                     {4{32'h7F80_0000}} };
        t3_rd_a = '{5'd28, 5'd29, 5'd30, 5'd31};
        t3_wr   = '{5'd30, 5'd31, 5'd0, 5'd1};

        repeat (2) @(negedge clock);
        checkFlag("reset_ready", bus.request_ready, 1'b1);
        checkFlag("reset_busy", bus.busy, 1'b0);
        checkFlag("reset_done", bus.done, 1'b0);
        checkFlag("reset_read_enable", bus.rf_read_enable, 1'b0);
        checkFlag("reset_write_enable", bus.rf_write_enable, 1'b0);
        checkAddress("reset_write_address", bus.rf_write_address, 5'd0);
        checkOutput("reset_write_data", bus.rf_write_data, '0);
        n_reset = 1'b1;

        $display("[TB] test 1: vfmin_64 single register");
        preloadRegister(5'd8,  {2{64'h4000_0000_0000_0000}});
        preloadRegister(5'd16, {2{64'h3FF0_0000_0000_0000}});
        applyStimulus(OP_VFMIN, SEW_64, 2'd0, 5'd8, 5'd16, 5'd24);
        @(negedge clock);
        checkFlag("t1_c1_read_enable", bus.rf_read_enable, 1'b1);
        checkAddress("t1_c1_read_a", bus.rf_read_address_a, 5'd8);
        checkAddress("t1_c1_read_b", bus.rf_read_address_b, 5'd16);
        checkFlag("t1_c1_write_enable", bus.rf_write_enable, 1'b0);
        checkFlag("t1_c1_busy", bus.busy, 1'b1);
        checkFlag("t1_c1_ready", bus.request_ready, 1'b0);
        @(negedge clock);
        checkFlag("t1_c2_write_enable", bus.rf_write_enable, 1'b1);
        checkAddress("t1_c2_write_address", bus.rf_write_address, 5'd24);
        checkOutput("t1_c2_write_data", bus.rf_write_data, {2{64'h3FF0_0000_0000_0000}});
        checkFlag("t1_c2_done", bus.done, 1'b1);
        checkFlag("t1_c2_read_enable", bus.rf_read_enable, 1'b0);
        checkFlag("t1_c2_ready", bus.request_ready, 1'b0);
        @(negedge clock);
        checkFlag("t1_c3_ready", bus.request_ready, 1'b1);
        checkFlag("t1_c3_busy", bus.busy, 1'b0);
        checkFlag("t1_c3_done", bus.done, 1'b0);
        checkFlag("t1_c3_write_enable", bus.rf_write_enable, 1'b0);

        $display("[TB] test 2: vfmax_32 four registers");
        preloadRegister(5'd0, {32'h3F80_0000, 32'hC000_0000, 32'h4040_0000, 32'h0000_0000});
        preloadRegister(5'd4, {32'h4000_0000, 32'hBF80_0000, 32'h4040_0000, 32'h8000_0000});
        preloadRegister(5'd1, {4{32'h3F80_0000}});
        preloadRegister(5'd5, {4{32'h4000_0000}});
        preloadRegister(5'd2, {4{32'hC040_0000}});
        preloadRegister(5'd6, {4{32'hC080_0000}});
        preloadRegister(5'd3, {4{32'h7F80_0000}});
        preloadRegister(5'd7, {4{32'hFF80_0000}});
        applyStimulus(OP_VFMAX, SEW_32, 2'd2, 5'd0, 5'd4, 5'd8);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            checkFlag($sformatf("t2_c%0d_read_enable", c), bus.rf_read_enable, c <= 4);
            if (c <= 4) begin
                checkAddress($sformatf("t2_c%0d_read_a", c), bus.rf_read_address_a, t2_rd_a[c-1]);
                checkAddress($sformatf("t2_c%0d_read_b", c), bus.rf_read_address_b, t2_rd_b[c-1]);
            end
            checkFlag($sformatf("t2_c%0d_write_enable", c), bus.rf_write_enable, c >= 2 && c <= 5);
            if (c >= 2 && c <= 5) begin
                checkAddress($sformatf("t2_c%0d_write_address", c), bus.rf_write_address, t2_wr[c-2]);
                checkOutput($sformatf("t2_c%0d_write_data", c), bus.rf_write_data, t2_data[c-2]);
            end
            checkFlag($sformatf("t2_c%0d_done", c), bus.done, c == 5);
            checkFlag($sformatf("t2_c%0d_busy", c), bus.busy, c <= 5);
            checkFlag($sformatf("t2_c%0d_ready", c), bus.request_ready, c == 6);
        end

        $display("[TB] test 3: address wrap");
        for (int r = 12; r <= 15; r++) preloadRegister(5'(r), {4{32'h3F80_0000}});
        for (int r = 28; r <= 31; r++) preloadRegister(5'(r), {4{32'h4000_0000}});
        applyStimulus(OP_VFMIN, SEW_32, 2'd2, 5'd28, 5'd12, 5'd30);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            if (c <= 4) begin
                checkAddress($sformatf("t3_c%0d_read_a", c), bus.rf_read_address_a, t3_rd_a[c-1]);
            end
            if (c >= 2) begin
                checkFlag($sformatf("t3_c%0d_write_enable", c), bus.rf_write_enable, 1'b1);
                checkAddress($sformatf("t3_c%0d_write_address", c), bus.rf_write_address, t3_wr[c-2]);
                checkOutput($sformatf("t3_c%0d_write_data", c), bus.rf_write_data, {4{32'h3F80_0000}});
            end
        end
        @(negedge clock);

        $display("[TB] test 4: back-to-back requests");
        snapshot_writes = write_count;
        snapshot_dones  = done_count;
        handshakes      = 0;
        bus.execution_vector = '{op: OP_VFMAX, sew: SEW_64};
        bus.lmul_log2        = 2'd1;
        bus.vs2_address      = 5'd16;
        bus.vs1_address      = 5'd18;
        bus.vd_address       = 5'd20;
        bus.request_valid    = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge clock);
            if (c == 9) bus.request_valid = 1'b0;
            checkFlag($sformatf("t4_c%0d_ready", c), bus.request_ready, (c % 4) == 0);
            if (bus.request_valid && bus.request_ready) handshakes++;
        end
        checkCount("t4_handshakes", handshakes, 3);
        checkCount("t4_writes", write_count - snapshot_writes, 6);
        checkCount("t4_dones", done_count - snapshot_dones, 3);

        $display("[TB] test 5: reset mid-operation");
        applyStimulus(OP_VFMIN, SEW_64, 2'd3, 5'd0, 5'd8, 5'd16);
        repeat (3) @(negedge clock);
        checkFlag("t5_c3_write_enable", bus.rf_write_enable, 1'b1);
        checkFlag("t5_c3_busy", bus.busy, 1'b1);
        #2;
        n_reset = 1'b0;
        #1;
        checkFlag("t5_reset_write_enable", bus.rf_write_enable, 1'b0);
        checkFlag("t5_reset_busy", bus.busy, 1'b0);
        checkFlag("t5_reset_done", bus.done, 1'b0);
        checkFlag("t5_reset_read_enable", bus.rf_read_enable, 1'b0);
        repeat (2) @(negedge clock);
        n_reset = 1'b1;
        snapshot_writes = write_count;
        repeat (12) @(negedge clock);
        checkCount("t5_writes_after_release", write_count - snapshot_writes, 0);
        checkFlag("t5_ready_after_release", bus.request_ready, 1'b1);
        checkFlag("t5_busy_after_release", bus.busy, 1'b0);

        $display("[TB] test 6: NaN and signed zero");
        preloadRegister(5'd1, {64'h0000_0000_0000_0000, 64'h7FF8_0000_0000_0000});
        preloadRegister(5'd2, {64'h8000_0000_0000_0000, 64'hC000_0000_0000_0000});
        applyStimulus(OP_VFMIN, SEW_64, 2'd0, 5'd1, 5'd2, 5'd3);
        repeat (2) @(negedge clock);
        checkFlag("t6_write_enable", bus.rf_write_enable, 1'b1);
        checkAddress("t6_write_address", bus.rf_write_address, 5'd3);
        checkOutput("t6_write_data", bus.rf_write_data,
                    {64'h8000_0000_0000_0000, 64'hC000_0000_0000_0000});
        checkFlag("t6_done", bus.done, 1'b1);
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
